// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
interface serial_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             ovf;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow, ovf
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow, ovf
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: DIFF = A - B, LSB first, one
// full-adder slice fed A, ~B and an initial carry of 1.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input logic               clk,
  input logic               rst,
  serial_subtractor_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  // Holds only the WIDTH-1 earlier bits; the MSB is joined on the last edge.
  logic [WIDTH-2:0] d_sr;
  logic [WIDTH-1:0] d_next;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             nb0;
  logic             s;
  logic             carry_nxt;
  logic             c_msb_in;
  logic             last_bit;
  logic [WIDTH-1:0] diff_r;
  logic             borrow_r;
  logic             ovf_r;
  logic             busy_c;
  logic             done_c;

  // Full-adder slice on the current LSBs plus the assembled result word.
  always_comb begin
    nb0       = ~b_sr[0];
    s         = a_sr[0] ^ nb0 ^ carry;
    carry_nxt = (a_sr[0] & nb0) | (carry & (a_sr[0] ^ nb0));
    c_msb_in  = carry;
    last_bit  = (cnt == LAST);
    d_next    = {s, d_sr};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (bus.start) state_nxt = RUN;
      RUN:  if (last_bit)  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded from the state register only.
  always_comb begin
    busy_c = (state != IDLE);
    done_c = (state == DONE);
  end

  // Operand shifting, serial accumulation and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr     <= '0;
      b_sr     <= '0;
      d_sr     <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      diff_r   <= '0;
      borrow_r <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            a_sr  <= bus.a;
            b_sr  <= bus.b;
            carry <= 1'b1;
            cnt   <= '0;
            d_sr  <= '0;
          end
        end
        RUN: begin
          carry <= carry_nxt;
          d_sr  <= d_next[WIDTH-1:1];
          a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
          cnt   <= cnt + 1'b1;
          if (last_bit) begin
            diff_r   <= d_next;
            borrow_r <= ~carry_nxt;
            ovf_r    <= c_msb_in ^ carry_nxt;
          end
        end
        DONE: cnt <= '0;
        default: ;
      endcase
    end
  end

  assign bus.busy   = busy_c;
  assign bus.done   = done_c;
  assign bus.diff   = diff_r;
  assign bus.borrow = borrow_r;
  assign bus.ovf    = ovf_r;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=4 and WIDTH=8.
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(4)) bus4 ();
  serial_subtractor_if #(.WIDTH(8)) bus8 ();

  serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accepting edge for the 4-bit unit; returns after edge 1.
  task automatic launch4(input logic [3:0] a, input logic [3:0] b);
    bus4.a     = a;
    bus4.b     = b;
    bus4.start = 1'b1;
    step();
    bus4.start = 1'b0;
  endtask

  // Edges counted from the accepting edge (edge 1) until done is seen.
  task automatic wait_done4(output int n);
    n = 1;
    while (!bus4.done && n < 20) begin
      step();
      n++;
    end
  endtask

  int          n;
  int          pulses;
  logic [3:0]  ed;
  logic        eb;
  logic        eo;

  initial begin
    rst        = 1'b1;
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;
    step();
    step();
    check("rst_busy",   32'(bus4.busy),   0);
    check("rst_done",   32'(bus4.done),   0);
    check("rst_diff",   32'(bus4.diff),   0);
    check("rst_borrow", 32'(bus4.borrow), 0);
    check("rst_ovf",    32'(bus4.ovf),    0);
    check("rst_busy8",  32'(bus8.busy),   0);
    rst = 1'b0;
    step();

    // 9 - 3: busy over edges 1..5, done only after edge 5.
    // -7 - 3 leaves the signed 4-bit range, so ovf is set.
    launch4(4'd9, 4'd3);
    for (int e = 1; e <= 4; e++) begin
      check($sformatf("t1_busy_e%0d", e), 32'(bus4.busy), 1);
      check($sformatf("t1_done_e%0d", e), 32'(bus4.done), 0);
      step();
    end
    check("t1_done_e5", 32'(bus4.done),   1);
    check("t1_busy_e5", 32'(bus4.busy),   1);
    check("t1_diff",    32'(bus4.diff),   6);
    check("t1_borrow",  32'(bus4.borrow), 0);
    check("t1_ovf",     32'(bus4.ovf),    1);
    step();
    check("t1_done_e6", 32'(bus4.done), 0);
    check("t1_busy_e6", 32'(bus4.busy), 0);
    check("t1_hold",    32'(bus4.diff), 6);

    // 3 - 9: borrow; 3 - (-7) = 10 overflows signed.
    launch4(4'd3, 4'd9);
    step();
    check("t2_run_hold", 32'(bus4.diff), 6);
    wait_done4(n);
    check("t2_lat",    32'(n + 1), 5);
    check("t2_diff",   32'(bus4.diff),   32'hA);
    check("t2_borrow", 32'(bus4.borrow), 1);
    check("t2_ovf",    32'(bus4.ovf),    1);
    step();

    // -8 - 1 overflows to +7.
    launch4(4'd8, 4'd1);
    wait_done4(n);
    check("t3a_lat",    32'(n), 5);
    check("t3a_diff",   32'(bus4.diff),   7);
    check("t3a_borrow", 32'(bus4.borrow), 0);
    check("t3a_ovf",    32'(bus4.ovf),    1);
    step();

    launch4(4'd15, 4'd15);
    wait_done4(n);
    check("t3b_diff",   32'(bus4.diff),   0);
    check("t3b_borrow", 32'(bus4.borrow), 0);
    check("t3b_ovf",    32'(bus4.ovf),    0);
    step();

    // 12 - 5 with start and new operands pulsed on edge 2; single done, result 7.
    launch4(4'd12, 4'd5);
    bus4.a = 4'd0; bus4.b = 4'd1; bus4.start = 1'b1;
    step();
    bus4.start = 1'b0;
    pulses = 0;
    for (int e = 0; e < 12; e++) begin
      if (bus4.done) begin
        pulses++;
        check("t4_diff",   32'(bus4.diff),   7);
        check("t4_borrow", 32'(bus4.borrow), 0);
        check("t4_ovf",    32'(bus4.ovf),    1);
      end
      step();
    end
    check("t4_pulses", 32'(pulses), 1);

    // Reset on edge 3 mid-RUN discards the operation.
    launch4(4'd9, 4'd3);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_busy", 32'(bus4.busy), 0);
    check("t5_done", 32'(bus4.done), 0);
    check("t5_diff", 32'(bus4.diff), 0);
    pulses = 0;
    for (int e = 0; e < 8; e++) begin
      if (bus4.done) pulses++;
      step();
    end
    check("t5_no_done", 32'(pulses), 0);
    launch4(4'd5, 4'd2);
    wait_done4(n);
    check("t5_lat",    32'(n), 5);
    check("t5_diff",   32'(bus4.diff),   3);
    check("t5_borrow", 32'(bus4.borrow), 0);
    step();

    // Start held high relaunches every WIDTH+2 cycles.
    bus4.a = 4'd7; bus4.b = 4'd2; bus4.start = 1'b1;
    step();
    wait_done4(n);
    check("t6_first", 32'(n), 5);
    step();
    n = 1;
    while (!bus4.done && n < 20) begin
      step();
      n++;
    end
    check("t6_period", 32'(n), 6);
    check("t6_diff",   32'(bus4.diff), 5);
    bus4.start = 1'b0;
    step();

    // 8-bit: 200 - 55 = 145, done after edge 9.
    bus8.a = 8'd200; bus8.b = 8'd55; bus8.start = 1'b1;
    step();
    bus8.start = 1'b0;
    n = 1;
    while (!bus8.done && n < 30) begin
      step();
      n++;
    end
    check("t7_lat",    32'(n), 9);
    check("t7_diff",   32'(bus8.diff),   145);
    check("t7_borrow", 32'(bus8.borrow), 0);
    check("t7_ovf",    32'(bus8.ovf),    0);
    step();

    // Exhaustive 4-bit sweep against an arithmetic reference.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        ed = 4'(ia - ib);
        eb = (ia < ib);
        eo = (ia[3] != ib[3]) && (ed[3] != ia[3]);
        launch4(4'(ia), 4'(ib));
        wait_done4(n);
        check($sformatf("sw_lat_%0d_%0d", ia, ib),  32'(n), 5);
        check($sformatf("sw_diff_%0d_%0d", ia, ib), 32'(bus4.diff), 32'(ed));
        check($sformatf("sw_brw_%0d_%0d", ia, ib),  32'(bus4.borrow), 32'(eb));
        check($sformatf("sw_ovf_%0d_%0d", ia, ib),  32'(bus4.ovf), 32'(eo));
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
